// File: rtl/dfcnq_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dfcnq_pipe
// Purpose  : Parametrised elastic pipeline register with asynchronous clear,
//            per-stage valid bits, valid/ready backpressure with bubble
//            collapsing, synchronous flush and a registered occupancy count.
// Ports    : CP    - clock, rising edge
//            CDN   - asynchronous active-low clear
//            D/DV  - upstream data / valid
//            DR    - ready to upstream (combinational)
//            Q/QV  - registered output data / valid (last stage)
//            QR    - downstream ready
//            FLUSH - synchronous discard of all stage contents
//            CNT   - number of valid stages (registered)
// Revision : 1.0 - initial release
// ============================================================================
module dfcnq_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic             DR,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    input  logic             QR,
    input  logic             FLUSH,
    output logic [CNTW-1:0]  CNT
);

    logic [WIDTH-1:0] data [DEPTH];
    logic [WIDTH-1:0] src  [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] mv;
    logic [DEPTH-1:0] ld;
    logic [CNTW-1:0]  cnt;
    logic             accept;
    logic             deliver;

    // Move chain runs from the output back to the input: a stage may move
    // when the stage ahead is empty or is itself moving. This is what
    // collapses bubbles while still sustaining one word per cycle.
    always_comb begin
        mv            = '0;
        mv[DEPTH-1]   = v[DEPTH-1] & QR;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            mv[i] = v[i] & (~v[i+1] | mv[i+1]);
        end
    end

    assign DR      = ~FLUSH & (~v[0] | mv[0]);
    assign accept  = DV & DR;
    assign deliver = v[DEPTH-1] & QR;

    // Per-stage load enable and upstream source selection.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign ld[i]  = accept;
            assign src[i] = D;
        end else begin : g_body
            assign ld[i]  = mv[i-1];
            assign src[i] = data[i-1];
        end
    end

    // Data registers are enabled only on a load, so empty shifts and flushes
    // leave them untouched; only the valid bits carry occupancy.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
            v <= '0;
        end else if (FLUSH) begin
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ld[i]) begin
                    data[i] <= src[i];
                    v[i]    <= 1'b1;
                end else if (mv[i]) begin
                    v[i]    <= 1'b0;
                end
            end
        end
    end

    // Occupancy tracks accepts minus deliveries; a flush drops everything
    // even though the delivery in that cycle is still considered complete.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            cnt <= '0;
        end else if (FLUSH) begin
            cnt <= '0;
        end else begin
            case ({accept, deliver})
                2'b10:   cnt <= cnt + CNTW'(1);
                2'b01:   cnt <= cnt - CNTW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign Q   = data[DEPTH-1];
    assign QV  = v[DEPTH-1];
    assign CNT = cnt;

`ifndef SYNTHESIS
    // An unknown valid while the pipe is ready would corrupt occupancy.
    a_dv_known : assert property (@(posedge CP) disable iff (!CDN)
        DR |-> !$isunknown(DV));
`endif

endmodule
`default_nettype wire

// File: tb/tb_dfcnq_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dfcnq_pipe
// Purpose  : Self-checking bench for dfcnq_pipe. One instance with
//            WIDTH=8/DEPTH=3 runs a vector table and hand-written corner
//            sequences; a second WIDTH=1/DEPTH=1 instance runs random traffic.
//            Both are checked against a queue scoreboard whose occupancy
//            drives the expected ready and count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dfcnq_pipe;

    logic       CP;
    logic       CDN;
    logic [7:0] D;
    logic       DV;
    logic       DR;
    logic [7:0] Q;
    logic       QV;
    logic       QR;
    logic       FLUSH;
    logic [1:0] CNT;

    logic       d1_d;
    logic       d1_dv;
    logic       d1_dr;
    logic       d1_q;
    logic       d1_qv;
    logic       d1_qr;
    logic       d1_fl;
    logic       d1_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] sb [$];
    logic       sb1 [$];

    dfcnq_pipe #(.WIDTH(8), .DEPTH(3)) u_dut (
        .CP(CP), .CDN(CDN), .D(D), .DV(DV), .DR(DR), .Q(Q), .QV(QV),
        .QR(QR), .FLUSH(FLUSH), .CNT(CNT)
    );

    dfcnq_pipe #(.WIDTH(1), .DEPTH(1)) u_d1 (
        .CP(CP), .CDN(CDN), .D(d1_d), .DV(d1_dv), .DR(d1_dr), .Q(d1_q),
        .QV(d1_qv), .QR(d1_qr), .FLUSH(d1_fl), .CNT(d1_cnt)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the 8x3 instance. Called at a falling edge; returns at
    // the next falling edge with the scoreboard updated and CNT checked.
    task automatic cycle(input logic dv, input logic [7:0] d, input logic qr,
                         input logic fl, output logic dr_seen);
        logic exp_rdy;
        logic acc;
        logic dlv;
        DV = dv; D = d; QR = qr; FLUSH = fl;
        #1;
        exp_rdy = !fl && (sb.size() < 3 || qr);
        dr_seen = DR;
        chk("dr_model", {31'd0, DR}, {31'd0, exp_rdy});
        if (sb.size() == 0) chk("qv_when_empty", {31'd0, QV}, 32'd0);
        dlv = QV && qr;
        if (dlv) begin
            if (sb.size() == 0) chk("deliver_underflow", 32'd1, 32'd0);
            else                chk("q_data", {24'd0, Q}, {24'd0, sb[0]});
        end
        acc = dv && exp_rdy;
        @(posedge CP);
        if (dlv && sb.size() > 0) void'(sb.pop_front());
        if (acc) sb.push_back(d);
        if (fl) sb.delete();
        @(negedge CP);
        chk("cnt_model", {30'd0, CNT}, sb.size());
    endtask

    typedef struct {
        logic       dv;
        logic [7:0] d;
        logic       qr;
        logic       dr;
        logic       qv;
        logic [7:0] q;
        logic [1:0] cnt;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic dr_s;
        logic exp_rdy1;
        logic dlv1;
        logic acc1;

        vecs = '{
            '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1},
            '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 2'd2},
            '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h11, 2'd3},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 2'd2},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2'd1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33, 2'd0},
            '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h33, 2'd1},
            '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h33, 2'd2},
            '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd3},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd3},
            '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd3},
            '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd3},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 2'd2},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 2'd1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA4, 2'd0}
        };

        CDN = 1'b0; D = 8'h00; DV = 1'b0; QR = 1'b0; FLUSH = 1'b0;
        d1_d = 1'b0; d1_dv = 1'b0; d1_qr = 1'b0; d1_fl = 1'b0;

        // Reset state
        #1;
        chk("rst_q",   {24'd0, Q},   32'd0);
        chk("rst_qv",  {31'd0, QV},  32'd0);
        chk("rst_cnt", {30'd0, CNT}, 32'd0);
        chk("rst_dr",  {31'd0, DR},  32'd1);
        @(negedge CP);
        CDN = 1'b1;

        // Streaming and full-pipe backpressure from the vector table
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].dv, vecs[i].d, vecs[i].qr, 1'b0, dr_s);
            chk($sformatf("vec%0d_dr", i),  {31'd0, dr_s}, {31'd0, vecs[i].dr});
            chk($sformatf("vec%0d_qv", i),  {31'd0, QV},   {31'd0, vecs[i].qv});
            chk($sformatf("vec%0d_q", i),   {24'd0, Q},    {24'd0, vecs[i].q});
            chk($sformatf("vec%0d_cnt", i), {30'd0, CNT},  {30'd0, vecs[i].cnt});
        end

        // Bubble collapse: 0x05 parks at the output, 0x06 closes up behind it
        cycle(1'b1, 8'h05, 1'b0, 1'b0, dr_s);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, dr_s);
            chk("bub_dr", {31'd0, dr_s}, 32'd1);
        end
        cycle(1'b1, 8'h06, 1'b0, 1'b0, dr_s);
        chk("bub_dr_send", {31'd0, dr_s}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, dr_s);
        chk("bub_cnt", {30'd0, CNT}, 32'd2);
        chk("bub_q",   {24'd0, Q},   32'h05);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, dr_s);
        chk("bub_next_qv", {31'd0, QV}, 32'd1);
        chk("bub_next_q",  {24'd0, Q},  32'h06);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, dr_s);
        chk("bub_drain_qv", {31'd0, QV}, 32'd0);

        // Flush of a full pipe while delivering and offering new data
        cycle(1'b1, 8'hB1, 1'b0, 1'b0, dr_s);
        cycle(1'b1, 8'hB2, 1'b0, 1'b0, dr_s);
        cycle(1'b1, 8'hB3, 1'b0, 1'b0, dr_s);
        cycle(1'b1, 8'hBF, 1'b1, 1'b1, dr_s);
        chk("fl_dr",  {31'd0, dr_s}, 32'd0);
        chk("fl_qv",  {31'd0, QV},   32'd0);
        chk("fl_cnt", {30'd0, CNT},  32'd0);
        chk("fl_q_hold", {24'd0, Q}, 32'hB1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, dr_s);
        chk("fl_after_dr", {31'd0, dr_s}, 32'd1);
        chk("fl_after_cnt", {30'd0, CNT}, 32'd0);

        // Asynchronous clear between clock edges
        cycle(1'b1, 8'hC1, 1'b0, 1'b0, dr_s);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0, dr_s);
        DV = 1'b0;
        chk("cdn_pre_cnt", {30'd0, CNT}, 32'd2);
        #2;
        CDN = 1'b0;
        #1;
        chk("cdn_q",   {24'd0, Q},   32'd0);
        chk("cdn_qv",  {31'd0, QV},  32'd0);
        chk("cdn_cnt", {30'd0, CNT}, 32'd0);
        chk("cdn_dr",  {31'd0, DR},  32'd1);
        #1;
        CDN = 1'b1;
        sb.delete();
        @(negedge CP);
        cycle(1'b1, 8'h7E, 1'b1, 1'b0, dr_s);
        chk("lat_qv1", {31'd0, QV}, 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, dr_s);
        chk("lat_qv2", {31'd0, QV}, 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, dr_s);
        chk("lat_qv3", {31'd0, QV}, 32'd1);
        chk("lat_q3",  {24'd0, Q},  32'h7E);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, dr_s);
        chk("lat_drain_qv", {31'd0, QV}, 32'd0);

        // Random traffic on the single-stage, single-bit instance
        DV = 1'b0; QR = 1'b1; FLUSH = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            d1_dv = 1'($urandom_range(0, 1));
            d1_d  = 1'($urandom_range(0, 1));
            d1_qr = 1'($urandom_range(0, 1));
            d1_fl = ($urandom_range(0, 31) == 0);
            #1;
            exp_rdy1 = !d1_fl && (sb1.size() < 1 || d1_qr);
            chk("d1_dr", {31'd0, d1_dr}, {31'd0, exp_rdy1});
            chk("d1_qv", {31'd0, d1_qv}, (sb1.size() > 0) ? 32'd1 : 32'd0);
            dlv1 = d1_qv && d1_qr;
            if (dlv1 && sb1.size() > 0)
                chk("d1_q", {31'd0, d1_q}, {31'd0, sb1[0]});
            acc1 = d1_dv && exp_rdy1;
            @(posedge CP);
            if (dlv1 && sb1.size() > 0) void'(sb1.pop_front());
            if (acc1) sb1.push_back(d1_d);
            if (d1_fl) sb1.delete();
            @(negedge CP);
            chk("d1_cnt", {31'd0, d1_cnt}, sb1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
